spi_slave_ctrl: RTL

//  SPI slave front-end that sequences the single-port SPI RAM (10-bit command/data word in, 8-bit data out).
//  - Deserialises MOSI frames into rx_data with a one-cycle rx_valid strobe.
//  - Tracks read-address/read-data ordering.
//  - Serialises the RAM's tx_data back out on MISO.
//  - Sits between the external SPI pins and the RAM; one frame per ss_n low period.

---
 rtl/spi_slave_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end for the single-port SPI RAM.
//   Deserialises one {cmd[1:0], payload} frame per ss_n low period into rx_data
//   with a one-cycle rx_valid strobe. It tracks read-address/read-data ordering
//   and serialises the RAM read data back out on miso, MSB first.
// Ports:
//   clk, rst_n  system clock (one SPI bit per rising edge), async active-low reset
//   ss_n        slave select, active low, frames a transfer
//   mosi        serial data in, MSB first
//   miso        serial data out, MSB first
//   rx_data     assembled frame {cmd, payload}, ADDR_SIZE+2 bits
//   rx_valid    one-cycle strobe when rx_data is complete
//   tx_data     RAM read data, ADDR_SIZE bits
//   tx_valid    RAM read data valid
//   abort_err   (SPI_ABORT_FLAG_EN only) one-cycle pulse on an early ss_n rise
// Optional feature macro: SPI_ABORT_FLAG_EN
module spi_slave_ctrl #(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_ABORT_FLAG_EN
  ,
  output logic                 abort_err
`endif
);

  localparam int unsigned FW    = ADDR_SIZE + 2;
  localparam int unsigned CNT_W = $clog2(FW + 1);
  localparam int unsigned TXC_W = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_CMD   = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_ADD  = 3'd3,
    S_READ_DATA = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;     // frame bits sampled so far
  logic [TXC_W-1:0]     r_tx_cnt;      // read bits placed on miso; 0 = waiting for tx_valid
  logic [ADDR_SIZE-1:0] r_tx_sr;
  logic [FW-1:0]        r_rx_data;
  logic                 r_rx_valid;
  logic                 r_miso;
  logic                 r_rd_addr_seen;
  logic                 w_in_frame;
  logic                 w_shifting_in;
  logic                 w_last_bit;

  assign w_in_frame    = (r_state == S_WRITE) || (r_state == S_READ_ADD) ||
                         (r_state == S_READ_DATA);
  assign w_shifting_in = w_in_frame && (r_bit_cnt < CNT_W'(FW));
  assign w_last_bit    = w_shifting_in && (r_bit_cnt == CNT_W'(FW - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: command MSB plus read-order flag selects the frame type
  always_comb begin
    w_state_nxt = r_state;
    if (ss_n) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_CHK_CMD;
        S_CHK_CMD: begin
          if (!mosi)               w_state_nxt = S_WRITE;
          else if (r_rd_addr_seen) w_state_nxt = S_READ_DATA;
          else                     w_state_nxt = S_READ_ADD;
        end
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Shift-in, read-order flag and shift-out datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_tx_cnt       <= '0;
      r_tx_sr        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_miso         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (ss_n) begin
        r_bit_cnt <= '0;
        r_tx_cnt  <= '0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_bit_cnt <= '0;
          S_CHK_CMD: begin
            r_rx_data <= {(FW - 1)'(0), mosi};
            r_bit_cnt <= CNT_W'(1);
          end
          S_WRITE, S_READ_ADD, S_READ_DATA: begin
            if (w_shifting_in) begin
              r_rx_data <= {r_rx_data[FW-2:0], mosi};
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (w_last_bit) begin
                r_rx_valid <= 1'b1;
                if (r_state == S_READ_ADD)  r_rd_addr_seen <= 1'b1;
                if (r_state == S_READ_DATA) r_rd_addr_seen <= 1'b0;
              end
            end else if (r_state == S_READ_DATA) begin
              // Latch once; a held tx_valid cannot restart the shift
              if (r_tx_cnt == '0) begin
                if (tx_valid) begin
                  r_tx_sr  <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                  r_miso   <= tx_data[ADDR_SIZE-1];
                  r_tx_cnt <= TXC_W'(1);
                end
              end else if (r_tx_cnt < TXC_W'(ADDR_SIZE)) begin
                r_miso   <= r_tx_sr[ADDR_SIZE-1];
                r_tx_sr  <= {r_tx_sr[ADDR_SIZE-2:0], 1'b0};
                r_tx_cnt <= r_tx_cnt + TXC_W'(1);
              end else begin
                r_miso <= 1'b0;
              end
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

`ifdef SPI_ABORT_FLAG_EN
  logic r_abort_err;
  logic w_abort;

  // Early ss_n rise: frame incomplete, or read data not fully shifted out
  assign w_abort = ss_n && ((r_state == S_CHK_CMD) || w_shifting_in ||
                   ((r_state == S_READ_DATA) && (r_tx_cnt < TXC_W'(ADDR_SIZE))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_abort_err <= 1'b0;
    else        r_abort_err <= w_abort;
  end

  assign abort_err = r_abort_err;
`endif

  assign miso     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule
